// File: rtl/sprite_sched_pkg.sv
// Shared state encoding, display-list entry layout and default geometry for
// the sprite draw scheduler.
package sprite_sched_pkg;
  localparam int DEF_MAX_SPRITES = 32;
  localparam int DEF_SCREEN_W    = 640;
  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_SPRITE_DIM  = 16;
  localparam int DEF_TIMEOUT     = 4095;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CHECK   = 3'd2,
    S_ISSUE   = 3'd3,
    S_RELEASE = 3'd4,
    S_FINISH  = 3'd5
  } sched_state_e;

  typedef struct packed {
    logic [2:0] img_id;
    logic [9:0] x;
    logic [9:0] y;
  } sprite_entry_t;

  localparam int ENTRY_W = $bits(sprite_entry_t);

  // Coordinates are zero-extended to 11 bits so the limit compare never wraps.
  function automatic logic entry_clipped(input sprite_entry_t e,
                                         input logic [10:0] max_x,
                                         input logic [10:0] max_y);
    return ({1'b0, e.x} > max_x) || ({1'b0, e.y} > max_y);
  endfunction
endpackage

// File: rtl/sprite_draw_scheduler_ram.sv
// Double-banked display list: one write port, one synchronous read port,
// bank select is the address MSB.
module display_list_ram
  import sprite_sched_pkg::*;
#(
  parameter int DEPTH = 2 * DEF_MAX_SPRITES,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic [AW-1:0]      rd_addr_i,
  output logic [ENTRY_W-1:0] rd_data_o
);
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

// File: rtl/sprite_draw_scheduler.sv
// Walks the committed display list once per frame and drives the accelerator
// Start/Done handshake for every on-screen sprite.
module sprite_draw_scheduler
  import sprite_sched_pkg::*;
#(
  parameter int MAX_SPRITES = DEF_MAX_SPRITES,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int SPRITE_DIM  = DEF_SPRITE_DIM,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                           frame_clk,
  input  logic                           Reset,
  input  logic                           frame_start,
  input  logic                           wr_en,
  input  logic [$clog2(MAX_SPRITES)-1:0] wr_index,
  input  logic [2:0]                     wr_img_id,
  input  logic [9:0]                     wr_x,
  input  logic [9:0]                     wr_y,
  input  logic                           commit,
  input  logic [$clog2(MAX_SPRITES):0]   commit_len,
  output logic [2:0]                     img_id,
  output logic [9:0]                     imgX,
  output logic [9:0]                     imgY,
  output logic                           Start,
  input  logic                           Done,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun,
  output logic                           timeout,
  output logic [5:0]                     skipped,
  input  logic                           clear_status,
  output logic [2:0]                     dbg_state_o
);
  localparam int IW = $clog2(MAX_SPRITES);
  localparam int LW = IW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [10:0]   MAX_X   = 11'(SCREEN_W - SPRITE_DIM);
  localparam logic [10:0]   MAX_Y   = 11'(SCREEN_H - SPRITE_DIM);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_SPRITES);
  localparam logic [TW-1:0] TMO     = TW'(TIMEOUT);

  sched_state_e  state_q;
  logic          active_bank_q, pend_q, restart_pend_q;
  logic [LW-1:0] active_len_q, pend_len_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    img_id_q;
  logic [9:0]    imgx_q, imgy_q;
  logic          start_q, frame_done_q, overrun_q, timeout_q;
  logic [5:0]    skipped_q;

  logic [ENTRY_W-1:0] rd_data;
  sprite_entry_t      rd_entry;
  logic               clip, last_entry, advance, overrun_evt, restart_now;
  logic               start_walk, swap_now;
  logic [LW-1:0]      commit_len_c, start_len;

  display_list_ram #(.DEPTH(2 * MAX_SPRITES)) u_ram (
    .clk_i     (frame_clk),
    .wr_en_i   (wr_en),
    .wr_addr_i ({~active_bank_q, wr_index}),
    .wr_data_i ({wr_img_id, wr_x, wr_y}),
    .rd_addr_i ({active_bank_q, idx_q}),
    .rd_data_o (rd_data)
  );

  assign rd_entry = sprite_entry_t'(rd_data);

  // start_walk covers both a fresh frame from IDLE and a restart after overrun.
  always_comb begin
    clip         = entry_clipped(rd_entry, MAX_X, MAX_Y);
    last_entry   = (LW'(idx_q) + LW'(1)) == active_len_q;
    advance      = ((state_q == S_CHECK) && clip) ||
                   ((state_q == S_RELEASE) && !Done);
    overrun_evt  = frame_start && (state_q != S_IDLE);
    restart_now  = restart_pend_q || overrun_evt;
    start_walk   = ((state_q == S_IDLE) && frame_start) ||
                   ((advance || (state_q == S_FINISH)) && restart_now);
    commit_len_c = (commit_len > LEN_MAX) ? LEN_MAX : commit_len;
    swap_now     = pend_q || commit;
    start_len    = !swap_now ? active_len_q : (commit ? commit_len_c : pend_len_q);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      active_bank_q  <= 1'b0;
      pend_q         <= 1'b0;
      restart_pend_q <= 1'b0;
      active_len_q   <= '0;
      pend_len_q     <= '0;
      idx_q          <= '0;
      timer_q        <= '0;
      img_id_q       <= '0;
      imgx_q         <= '0;
      imgy_q         <= '0;
      start_q        <= 1'b0;
      frame_done_q   <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
      skipped_q      <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (clear_status) begin
        overrun_q <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (overrun_evt) overrun_q <= 1'b1;
      if (state_q == S_CHECK) begin
        img_id_q <= rd_entry.img_id;
        imgx_q   <= rd_entry.x;
        imgy_q   <= rd_entry.y;
      end
      if (start_walk) begin
        if (swap_now) begin
          active_bank_q <= ~active_bank_q;
          active_len_q  <= start_len;
        end
        pend_q         <= 1'b0;
        restart_pend_q <= 1'b0;
        idx_q          <= '0;
        skipped_q      <= '0;
        state_q        <= (start_len == '0) ? S_FINISH : S_LOAD;
      end else begin
        if (commit) begin
          pend_q     <= 1'b1;
          pend_len_q <= commit_len_c;
        end
        if (overrun_evt) restart_pend_q <= 1'b1;
        case (state_q)
          S_LOAD: state_q <= S_CHECK;
          S_CHECK: begin
            if (clip) begin
              if (skipped_q != 6'd63) skipped_q <= skipped_q + 6'd1;
            end else begin
              start_q <= 1'b1;
              timer_q <= TW'(1);
              state_q <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (Done) begin
              start_q <= 1'b0;
              state_q <= S_RELEASE;
            end else if (timer_q == TMO) begin
              start_q   <= 1'b0;
              timeout_q <= 1'b1;
              state_q   <= S_FINISH;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          S_FINISH: begin
            frame_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end
          default: ;
        endcase
        if (advance) begin
          if (last_entry) begin
            state_q <= S_FINISH;
          end else begin
            idx_q   <= idx_q + IW'(1);
            state_q <= S_LOAD;
          end
        end
      end
    end
  end

  assign img_id      = img_id_q;
  assign imgX        = imgx_q;
  assign imgY        = imgy_q;
  assign Start       = start_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign timeout     = timeout_q;
  assign skipped     = skipped_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Randomised and directed bench for sprite_draw_scheduler with a list-level
// reference model feeding command and frame scoreboards.
module tb_sprite_draw_scheduler;
  localparam int MAXS = 32;
  localparam int TMO  = 15;
  localparam int LIM_X = 640 - 16;
  localparam int LIM_Y = 480 - 16;

  logic        frame_clk = 1'b0;
  logic        Reset, frame_start, wr_en, commit, Done, clear_status;
  logic [4:0]  wr_index;
  logic [2:0]  wr_img_id;
  logic [9:0]  wr_x, wr_y;
  logic [5:0]  commit_len;
  logic [2:0]  img_id;
  logic [9:0]  imgX, imgY;
  logic        Start, busy, frame_done, overrun, timeout;
  logic [5:0]  skipped;
  logic [2:0]  dbg_state;

  logic [22:0] cmd_q[$];
  logic [5:0]  frame_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          resp_lat = 5;
  bit          resp_en = 1'b1;

  logic [22:0] m_bank [2][MAXS];
  int          m_active = 0;
  int          m_active_len = 0;
  bit          m_pend = 1'b0;
  int          m_pend_len = 0;

  sprite_draw_scheduler #(.TIMEOUT(TMO)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .frame_start(frame_start),
    .wr_en(wr_en), .wr_index(wr_index), .wr_img_id(wr_img_id),
    .wr_x(wr_x), .wr_y(wr_y), .commit(commit), .commit_len(commit_len),
    .img_id(img_id), .imgX(imgX), .imgY(imgY), .Start(Start), .Done(Done),
    .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .timeout(timeout), .skipped(skipped), .clear_status(clear_status),
    .dbg_state_o(dbg_state)
  );

  // Clock and watchdog
  always #5 frame_clk = ~frame_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: list-level view of banks and the commands a frame yields
  function automatic bit is_clipped(input logic [22:0] e);
    return (int'(e[19:10]) > LIM_X) || (int'(e[9:0]) > LIM_Y);
  endfunction

  task automatic model_commit(input int len);
    m_pend = 1'b1;
    m_pend_len = (len > MAXS) ? MAXS : len;
  endtask

  task automatic model_swap();
    if (m_pend) begin
      m_active = 1 - m_active;
      m_active_len = m_pend_len;
      m_pend = 1'b0;
    end
  endtask

  task automatic model_push_frame();
    int skip = 0;
    for (int i = 0; i < m_active_len; i++) begin
      if (is_clipped(m_bank[m_active][i])) skip++;
      else cmd_q.push_back(m_bank[m_active][i]);
    end
    frame_q.push_back(6'((skip > 63) ? 63 : skip));
  endtask

  // Driver tasks: entered and left on a falling edge
  task automatic write_entry(input int idx, input int img, input int x, input int y);
    wr_en = 1'b1; wr_index = 5'(idx); wr_img_id = 3'(img); wr_x = 10'(x); wr_y = 10'(y);
    m_bank[1 - m_active][idx] = {3'(img), 10'(x), 10'(y)};
    @(negedge frame_clk);
    wr_en = 1'b0;
  endtask

  task automatic do_commit(input int len);
    commit = 1'b1; commit_len = 6'(len);
    model_commit(len);
    @(negedge frame_clk);
    commit = 1'b0;
  endtask

  task automatic fire_frame(input bit with_commit, input int len);
    frame_start = 1'b1;
    if (with_commit) begin
      commit = 1'b1; commit_len = 6'(len);
      model_commit(len);
    end
    model_swap();
    model_push_frame();
    @(negedge frame_clk);
    frame_start = 1'b0; commit = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || cmd_q.size() != 0 || frame_q.size() != 0) && n < 3000) begin
      @(negedge frame_clk);
      n++;
    end
    if (busy || cmd_q.size() != 0 || frame_q.size() != 0)
      check({tag, "_idle_bound"}, 32'(busy) + 32'(cmd_q.size()) + 32'(frame_q.size()), 0);
    @(negedge frame_clk);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!Start && n < 50) begin
      @(negedge frame_clk);
      n++;
    end
    if (!Start) check({tag, "_start_seen"}, Start, 1);
  endtask

  // Accelerator model: Done after resp_lat cycles, dropped once Start falls
  initial begin
    Done = 1'b0;
    forever begin
      @(negedge frame_clk);
      if (resp_en && Start && !Done) begin
        repeat (resp_lat) @(negedge frame_clk);
        Done = 1'b1;
      end else if (Done && !Start) begin
        Done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboards whenever a command or frame_done appears
  initial begin
    logic start_prev = 1'b0;
    logic [22:0] exp_cmd;
    logic [5:0]  exp_skip;
    forever begin
      @(negedge frame_clk);
      if (Reset) begin
        start_prev = 1'b0;
      end else begin
        if (Start && !start_prev) begin
          if (cmd_q.size() == 0) check("unexpected_start", Start, 0);
          else begin
            exp_cmd = cmd_q.pop_front();
            check("cmd", {img_id, imgX, imgY}, exp_cmd);
          end
        end
        if (frame_done) begin
          if (frame_q.size() == 0) check("unexpected_frame_done", frame_done, 0);
          else begin
            exp_skip = frame_q.pop_front();
            check("frame_skipped", skipped, exp_skip);
            check("frame_done_busy", busy, 0);
          end
        end
        start_prev = Start;
      end
    end
  end

  initial begin
    int hi, n;
    Reset = 1'b1; frame_start = 1'b0; wr_en = 1'b0; wr_index = '0; wr_img_id = '0;
    wr_x = '0; wr_y = '0; commit = 1'b0; commit_len = '0; clear_status = 1'b0;
    repeat (3) @(negedge frame_clk);
    check("rst_start", Start, 0);
    check("rst_cmd", {img_id, imgX, imgY}, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    check("rst_timeout", timeout, 0);
    check("rst_skipped", skipped, 0);
    Reset = 1'b0;
    @(negedge frame_clk);

    // Nothing committed yet: an empty frame
    fire_frame(1'b0, 0);
    wait_idle("empty_after_reset");

    // Two entries, Start latency and ordering
    resp_lat = 5;
    write_entry(0, 1, 100, 50);
    write_entry(1, 0, 200, 60);
    do_commit(2);
    fire_frame(1'b0, 0);
    check("lat_load_start", Start, 0);
    check("lat_load_busy", busy, 1);
    @(negedge frame_clk);
    check("lat_check_start", Start, 0);
    @(negedge frame_clk);
    check("lat_issue_start", Start, 1);
    check("lat_issue_imgx", imgX, 100);
    wait_idle("two_entries");
    check("two_skipped", skipped, 0);

    // Clip boundaries
    write_entry(0, 0, 625, 10);
    write_entry(1, 1, 10, 465);
    write_entry(2, 2, 624, 464);
    do_commit(3);
    fire_frame(1'b0, 0);
    wait_idle("clip");
    check("clip_skipped", skipped, 2);

    // Empty list: frame_done two cycles after frame_start
    do_commit(0);
    fire_frame(1'b0, 0);
    check("empty_fd_c1", frame_done, 0);
    @(negedge frame_clk);
    check("empty_fd_c2", frame_done, 1);
    wait_idle("empty");

    // Shadow rewrite during a walk only affects the next frame
    write_entry(0, 3, 10, 20);
    write_entry(1, 4, 30, 40);
    write_entry(2, 5, 50, 60);
    do_commit(3);
    fire_frame(1'b0, 0);
    write_entry(0, 6, 110, 120);
    write_entry(1, 7, 130, 140);
    do_commit(2);
    check("shadow_busy", busy, 1);
    wait_idle("shadow_old");
    fire_frame(1'b0, 0);
    wait_idle("shadow_new");

    // Overrun during ISSUE: handshake completes, walk restarts from entry 0
    write_entry(0, 1, 11, 12);
    write_entry(1, 2, 13, 14);
    write_entry(2, 3, 15, 16);
    do_commit(3);
    frame_start = 1'b1;
    model_swap();
    cmd_q.push_back(m_bank[m_active][0]);
    @(negedge frame_clk);
    frame_start = 1'b0;
    wait_start("ovr");
    frame_start = 1'b1;
    model_push_frame();
    @(negedge frame_clk);
    frame_start = 1'b0;
    check("ovr_set", overrun, 1);
    wait_idle("ovr");
    check("ovr_sticky", overrun, 1);
    clear_status = 1'b1;
    @(negedge frame_clk);
    clear_status = 1'b0;
    check("ovr_cleared", overrun, 0);

    // Timeout: Done never arrives
    resp_en = 1'b0;
    write_entry(0, 3, 10, 10);
    write_entry(1, 4, 20, 20);
    do_commit(2);
    frame_start = 1'b1;
    model_swap();
    cmd_q.push_back(m_bank[m_active][0]);
    frame_q.push_back(6'd0);
    @(negedge frame_clk);
    frame_start = 1'b0;
    wait_start("tmo");
    hi = 0;
    while (Start && hi < 40) begin
      @(negedge frame_clk);
      hi++;
    end
    check("tmo_start_width", hi, TMO);
    check("tmo_flag", timeout, 1);
    wait_idle("tmo");
    check("tmo_busy", busy, 0);
    check("tmo_sticky", timeout, 1);
    clear_status = 1'b1;
    @(negedge frame_clk);
    clear_status = 1'b0;
    check("tmo_cleared", timeout, 0);
    resp_en = 1'b1;

    // Randomised frames
    for (int f = 0; f < 24; f++) begin
      int len;
      len = $urandom_range(0, 10);
      resp_lat = $urandom_range(1, 10);
      for (int i = 0; i < len; i++)
        write_entry(i, $urandom_range(0, 7), $urandom_range(0, 700), $urandom_range(0, 520));
      case ($urandom_range(0, 3))
        0: fire_frame(1'b0, 0);
        1: begin do_commit(len); fire_frame(1'b0, 0); end
        2: fire_frame(1'b1, len);
        default: begin
          do_commit($urandom_range(0, len));
          do_commit(len);
          fire_frame(1'b0, 0);
        end
      endcase
      wait_idle("rand");
    end

    // Reset in the middle of a handshake
    resp_lat = 8;
    write_entry(0, 5, 30, 30);
    do_commit(1);
    fire_frame(1'b0, 0);
    wait_start("rst_mid");
    Reset = 1'b1;
    cmd_q.delete();
    frame_q.delete();
    m_active = 0; m_active_len = 0; m_pend = 1'b0; m_pend_len = 0;
    @(negedge frame_clk);
    check("rst_mid_start", Start, 0);
    check("rst_mid_busy", busy, 0);
    @(negedge frame_clk);
    Reset = 1'b0;
    n = 0;
    repeat (12) @(negedge frame_clk);
    fire_frame(1'b0, 0);
    wait_idle("after_rst_mid");

    check("cmd_q_drained", cmd_q.size(), 0);
    check("frame_q_drained", frame_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sprite_draw_scheduler.md
# sprite_draw_scheduler

Sequences draw commands into the graphics accelerator once per displayed frame. Software fills a double-buffered display list of sprite entries (image id, X, Y); on each frame boundary the block walks the committed list in order and drives the accelerator's Start/Done handshake for every on-screen entry. It sits between the software register interface and the accelerator and provides overrun, timeout and clipping status.

## Interface
- MAX_SPRITES, 32: display-list entries per bank (power of two).
- SCREEN_W, 640; SCREEN_H, 480: visible frame size in pixels.
- SPRITE_DIM, 16: sprite edge length in pixels.
- TIMEOUT, 4095: maximum cycles Start may stay high without Done.
- frame_clk  in  1  clock. Reset: Reset, synchronous, active-high; clock: frame_clk.
- Reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- wr_en  in  1  write one entry into the shadow bank.
- wr_index  in  $clog2(MAX_SPRITES)  shadow entry address.
- wr_img_id  in  3; wr_x  in  10; wr_y  in  10: entry fields.
- commit  in  1  pulse: shadow bank becomes active at next frame start.
- commit_len  in  $clog2(MAX_SPRITES)+1  entry count, sampled on commit.
- img_id  out  3; imgX  out  10; imgY  out  10: command to accelerator.
- Start  out  1  accelerator request.
- Done  in  1  accelerator completion.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse when the list has been fully walked.
- overrun  out  1  sticky: frame_start arrived while busy.
- timeout  out  1  sticky: Done not seen within TIMEOUT cycles.
- skipped  out  6  entries clipped in the current frame, saturating at 63.
- clear_status  in  1  clears overrun and timeout.

## Operation
- States: IDLE, LOAD, CHECK, ISSUE, RELEASE, FINISH.
- IDLE: on frame_start → swap banks if commit pending (active_len ← latched len), idx ← 0, skipped ← 0; → FINISH if active_len = 0, else LOAD.
- LOAD: present {active_bank, idx} to list RAM → CHECK.
- CHECK: register entry onto img_id/imgX/imgY. Clip if x > SCREEN_W−SPRITE_DIM or y > SCREEN_H−SPRITE_DIM (compare in 11 bits); when clipped, skipped += 1 and advance. Otherwise → ISSUE.
- ISSUE: Start = 1, timer counts. Done = 1 → RELEASE. Timer = TIMEOUT → timeout ← 1, Start dropped, → FINISH (frame abandoned).
- RELEASE: Start = 0; wait for Done = 0, then advance.
- Advance: idx+1 = active_len → FINISH, else idx ← idx+1, → LOAD.
- FINISH: frame_done = 1 for one cycle → IDLE.
- Writes go only to the shadow bank, so they never conflict with the walk. A commit while one is already pending re-latches commit_len; the last one wins.
- commit and frame_start in the same cycle: the swap applies to this frame.
- frame_start while busy: overrun ← 1 and restart_pending ← 1. The current handshake completes through RELEASE, then the walk restarts at IDLE-start semantics, with the swap applied if pending. No frame_done pulse is given for the abandoned walk.
- clear_status together with a setting event: the set wins.

## Timing
- Reset values: Start 0, img_id/imgX/imgY 0, busy 0, frame_done 0, overrun 0, timeout 0, skipped 0. Both banks' lengths 0, active bank 0, no commit pending.
- Reset mid-handshake: Start is 0 from the following edge. RAM contents are not cleared.
- List RAM: synchronous read, 1-cycle latency.
- Start rises 3 cycles after the edge sampling frame_start (IDLE→LOAD→CHECK→ISSUE).
- Minimum per-entry cost is 4 cycles plus the accelerator latency. A clipped entry costs 2 cycles.
- Command outputs are stable from CHECK through RELEASE.

## Structure
- Package sprite_sched_pkg holds the state enum, the entry struct {img_id[2:0], x[9:0], y[9:0]}, and the default screen and sprite constants.
- Sub-module display_list_ram: 2×MAX_SPRITES × 23-bit, one write port, one synchronous read port, with bank as the address MSB.

## Test plan
- Reset, commit_len=2 with entries (1,100,50),(0,200,60), frame_start → Start rises 3 cycles later with imgX=100; Done responder (5-cycle latency) → second command imgX=200, then frame_done pulses once; skipped=0.
- Entry x=625 (clipped), y=465 (clipped), x=624/y=464 (drawn) → exactly one Start; skipped=2.
- commit_len=0, frame_start → frame_done pulses 2 cycles later; Start never asserted.
- Rewrite the shadow bank mid-walk and commit → the current frame uses the old entries and the next frame uses the new ones.
- frame_start during ISSUE → overrun=1; the handshake completes, then the walk restarts at idx 0; clear_status → overrun=0.
- Done held low, TIMEOUT=15 → Start drops after 15 cycles in ISSUE, timeout=1, frame_done pulses, busy=0.
